// File: rtl/sisc_pkg.sv
// Shared constants for the SISC control path: opcodes, state codes, ALU op encodings.
package sisc_pkg;

    // Opcode values; HLT is the all-ones opcode and is decoded by width
    localparam int unsigned OPC_NOOP = 0;
    localparam int unsigned OPC_LOD  = 1;
    localparam int unsigned OPC_STR  = 2;
    localparam int unsigned OPC_SWP  = 3;
    localparam int unsigned OPC_BRA  = 4;
    localparam int unsigned OPC_BRR  = 5;
    localparam int unsigned OPC_BNE  = 6;
    localparam int unsigned OPC_BNR  = 7;
    localparam int unsigned OPC_ALU  = 8;

    typedef logic [3:0] state_t;

    localparam state_t S_START1    = 4'd1;
    localparam state_t S_FETCH     = 4'd2;
    localparam state_t S_DECODE    = 4'd3;
    localparam state_t S_EXECUTE   = 4'd4;
    localparam state_t S_MEM       = 4'd5;
    localparam state_t S_WRITEBACK = 4'd6;
    localparam state_t S_MEMWAIT   = 4'd7;
    localparam state_t S_HALT      = 4'd8;

    // bit1: non-arithmetic (status not saved), bit0: immediate operand
    localparam logic [1:0] ALU_OP_ARITH     = 2'b00;
    localparam logic [1:0] ALU_OP_ARITH_IMM = 2'b01;
    localparam logic [1:0] ALU_OP_DEF       = 2'b10;
    localparam logic [1:0] ALU_OP_MEM_IMM   = 2'b11;

    localparam int unsigned IMM_MM_DEF = 8;

endpackage

// File: rtl/sisc_ctrl_v2_if.sv
// Controller <-> datapath bundle. master = control FSM, slave = datapath/memory side.
interface sisc_ctrl_v2_if #(
    parameter int unsigned OP_W = 4,
    parameter int unsigned MM_W = 4
);
    logic [OP_W-1:0] opcode;
    logic [MM_W-1:0] mm;
    logic [MM_W-1:0] stat;
    logic            dm_rdy;
    logic            resume;

    logic            rf_we;
    logic            wb_sel;
    logic            rd_sel;
    logic            br_sel;
    logic            pc_rst;
    logic            pc_write;
    logic            pc_sel;
    logic            ir_load;
    logic            dm_we;
    logic            dm_re;
    logic            mm_sel;
    logic [1:0]      alu_op;
    logic            halted;
    logic            bus_err;
    logic            illegal_op;
    logic [3:0]      state_o;

    modport master (
        input  opcode, mm, stat, dm_rdy, resume,
        output rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
               dm_we, dm_re, mm_sel, alu_op, halted, bus_err, illegal_op, state_o
    );

    modport slave (
        output opcode, mm, stat, dm_rdy, resume,
        input  rf_we, wb_sel, rd_sel, br_sel, pc_rst, pc_write, pc_sel, ir_load,
               dm_we, dm_re, mm_sel, alu_op, halted, bus_err, illegal_op, state_o
    );
endinterface

// File: rtl/sisc_br_eval.sv
// Branch condition evaluation: decides whether a branch opcode is taken and if it is absolute.
module sisc_br_eval
    import sisc_pkg::*;
#(
    parameter int unsigned OP_W = 4,
    parameter int unsigned MM_W = 4
) (
    input  logic [OP_W-1:0] opcode,
    input  logic [MM_W-1:0] mm,
    input  logic [MM_W-1:0] stat,
    output logic            taken,
    output logic            absolute
);
    logic hit;
    logic mm_zero;

    assign hit     = |(stat & mm);
    assign mm_zero = (mm == '0);

    // mm==0 is an unconditional branch for every branch flavour
    always_comb begin
        taken    = 1'b0;
        absolute = 1'b0;
        if (opcode == OP_W'(OPC_BRA) || opcode == OP_W'(OPC_BRR)) begin
            taken = mm_zero | hit;
        end else if (opcode == OP_W'(OPC_BNE) || opcode == OP_W'(OPC_BNR)) begin
            taken = mm_zero | ~hit;
        end
        absolute = (opcode == OP_W'(OPC_BRA)) || (opcode == OP_W'(OPC_BNE));
    end
endmodule

// File: rtl/sisc_ctrl_v2.sv
// SISC multi-cycle control FSM with memory wait/timeout, HALT/resume and illegal-opcode flag.
module sisc_ctrl_v2
    import sisc_pkg::*;
#(
    parameter int unsigned OP_W      = 4,
    parameter int unsigned MM_W      = 4,
    parameter int unsigned IMM_MM    = IMM_MM_DEF,
    parameter int unsigned WAIT_MAX  = 15,
    parameter bit          RESUME_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_f,
    sisc_ctrl_v2_if.master bus
);
    localparam int unsigned CW = (WAIT_MAX > 2) ? $clog2(WAIT_MAX) : 1;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           bus_err_q, bus_err_d;

    logic is_lod, is_str, is_alu, is_hlt, is_legal, is_mem, imm;
    logic br_taken, br_abs;

    assign is_lod = (bus.opcode == OP_W'(OPC_LOD));
    assign is_str = (bus.opcode == OP_W'(OPC_STR));
    assign is_alu = (bus.opcode == OP_W'(OPC_ALU));
    assign is_hlt = &bus.opcode;
    assign is_mem = is_lod | is_str;
    assign imm    = (bus.mm == MM_W'(IMM_MM));

    // SWP is deliberately not in the legal set
    assign is_legal = (bus.opcode == OP_W'(OPC_NOOP)) | is_lod | is_str | is_alu | is_hlt |
                      (bus.opcode == OP_W'(OPC_BRA)) | (bus.opcode == OP_W'(OPC_BRR)) |
                      (bus.opcode == OP_W'(OPC_BNE)) | (bus.opcode == OP_W'(OPC_BNR));

    sisc_br_eval #(
        .OP_W (OP_W),
        .MM_W (MM_W)
    ) u_br_eval (
        .opcode   (bus.opcode),
        .mm       (bus.mm),
        .stat     (bus.stat),
        .taken    (br_taken),
        .absolute (br_abs)
    );

    // State, wait counter and sticky bus error; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q   <= S_START1;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Next-state and datapath control decode
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        bus_err_d      = bus_err_q;
        bus.rf_we      = 1'b0;
        bus.wb_sel     = 1'b0;
        bus.rd_sel     = 1'b0;
        bus.br_sel     = 1'b0;
        bus.pc_rst     = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_sel     = 1'b0;
        bus.ir_load    = 1'b0;
        bus.dm_we      = 1'b0;
        bus.dm_re      = 1'b0;
        bus.mm_sel     = 1'b0;
        bus.alu_op     = ALU_OP_DEF;
        bus.halted     = 1'b0;
        bus.illegal_op = 1'b0;
        case (state_q)
            S_START1: begin
                bus.pc_rst = 1'b1;
                state_d    = S_FETCH;
            end
            S_FETCH: begin
                bus.ir_load  = 1'b1;
                bus.pc_write = 1'b1;
                state_d      = S_DECODE;
            end
            S_DECODE: begin
                bus.rd_sel     = ~is_mem;
                bus.illegal_op = ~is_legal;
                if (br_taken) begin
                    bus.pc_write = 1'b1;
                    bus.pc_sel   = 1'b1;
                    bus.br_sel   = br_abs;
                end
                state_d = is_hlt ? S_HALT : S_EXECUTE;
            end
            S_EXECUTE: begin
                if (is_alu) begin
                    bus.alu_op = {1'b0, imm};
                end else if (is_mem) begin
                    bus.alu_op = {1'b1, imm};
                    bus.mm_sel = (bus.mm == '0);
                end
                state_d = S_MEM;
            end
            S_MEM: begin
                bus.dm_re = is_lod;
                bus.dm_we = is_str;
                if (is_mem && (WAIT_MAX != 0) && !bus.dm_rdy) begin
                    state_d = S_MEMWAIT;
                    cnt_d   = '0;
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMWAIT: begin
                // Strobes held until the access completes; ready beats timeout
                bus.dm_re = is_lod;
                bus.dm_we = is_str;
                cnt_d     = cnt_q + CW'(1);
                if (bus.dm_rdy) begin
                    state_d = S_WRITEBACK;
                end else if (cnt_q == CW'(WAIT_MAX - 1)) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_WRITEBACK: begin
                bus.rf_we  = is_alu | is_lod;
                bus.wb_sel = is_lod;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                bus.halted = 1'b1;
                if (bus.resume && RESUME_EN && !bus_err_q) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_START1;
        endcase
    end

    assign bus.bus_err = bus_err_q;
    assign bus.state_o = state_q;

endmodule

// File: tb/tb_sisc_ctrl_v2.sv
// Table-driven bench for sisc_ctrl_v2: one row per clock cycle, plus hand-written reset sequences.
module tb_sisc_ctrl_v2;

    // Expected-vector field masks: {ctl[10:0], alu_op[1:0], misc[2:0], state[3:0]}
    localparam logic [10:0] RF_WE    = 11'b100_0000_0000;
    localparam logic [10:0] WB_SEL   = 11'b010_0000_0000;
    localparam logic [10:0] RD_SEL   = 11'b001_0000_0000;
    localparam logic [10:0] BR_SEL   = 11'b000_1000_0000;
    localparam logic [10:0] PC_RST   = 11'b000_0100_0000;
    localparam logic [10:0] PC_WRITE = 11'b000_0010_0000;
    localparam logic [10:0] PC_SEL   = 11'b000_0001_0000;
    localparam logic [10:0] IR_LOAD  = 11'b000_0000_1000;
    localparam logic [10:0] DM_WE    = 11'b000_0000_0100;
    localparam logic [10:0] DM_RE    = 11'b000_0000_0010;
    localparam logic [10:0] MM_SEL   = 11'b000_0000_0001;
    localparam logic [10:0] NONE     = 11'b000_0000_0000;
    localparam logic [2:0]  HALTED   = 3'b100;
    localparam logic [2:0]  BERR     = 3'b010;
    localparam logic [2:0]  ILL      = 3'b001;
    localparam logic [2:0]  M0       = 3'b000;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  mm;
        logic [3:0]  stat;
        logic        rdy;
        logic        res;
        logic [19:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_f;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t vecs[$];

    sisc_ctrl_v2_if #(.OP_W(4), .MM_W(4)) bus ();

    sisc_ctrl_v2 #(
        .OP_W      (4),
        .MM_W      (4),
        .IMM_MM    (8),
        .WAIT_MAX  (4),
        .RESUME_EN (1'b1)
    ) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] actual();
        return {bus.rf_we, bus.wb_sel, bus.rd_sel, bus.br_sel, bus.pc_rst, bus.pc_write,
                bus.pc_sel, bus.ir_load, bus.dm_we, bus.dm_re, bus.mm_sel, bus.alu_op,
                bus.halted, bus.bus_err, bus.illegal_op, bus.state_o};
    endfunction

    task automatic check(input string name, input int idx, input logic [19:0] exp);
        logic [19:0] act;
        act = actual();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %b required %b", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                       input logic rdy, input logic res, input logic [3:0] st,
                       input logic [10:0] ctl, input logic [1:0] alu, input logic [2:0] misc);
        vec_t v;
        v.op   = op;
        v.mm   = mm;
        v.stat = stat;
        v.rdy  = rdy;
        v.res  = res;
        v.exp  = {ctl, alu, misc, st};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] op, input logic [3:0] mm, input logic [3:0] stat,
                         input logic rdy, input logic res);
        bus.opcode = op;
        bus.mm     = mm;
        bus.stat   = stat;
        bus.dm_rdy = rdy;
        bus.resume = res;
    endtask

    // Rows lo..hi are consecutive cycles; no clock after the last row
    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].op, vecs[i].mm, vecs[i].stat, vecs[i].rdy, vecs[i].res);
            #1;
            check("row", i, vecs[i].exp);
            if (i != hi) begin
                @(posedge clk);
                #2;
            end
        end
    endtask

    initial begin
        // Segment 1 (rows 0..43): ALU imm, branches, LOD wait, illegal op, STR timeout
        add(8, 8, 0, 1, 0, 4'd1, PC_RST,            2'b10, M0);   // 0 START1
        add(8, 8, 0, 1, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0);  // 1 FETCH
        add(8, 8, 0, 1, 0, 4'd3, RD_SEL,            2'b10, M0);   // 2 DECODE
        add(8, 8, 0, 1, 0, 4'd4, NONE,              2'b01, M0);   // 3 EXECUTE imm
        add(8, 8, 0, 1, 0, 4'd5, NONE,              2'b10, M0);   // 4 MEM
        add(8, 8, 0, 1, 0, 4'd6, RF_WE,             2'b10, M0);   // 5 WRITEBACK
        add(4, 2, 2, 1, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0);  // 6 FETCH (BRA)
        add(4, 2, 2, 1, 0, 4'd3, RD_SEL | PC_WRITE | PC_SEL | BR_SEL, 2'b10, M0); // 7 taken abs
        add(4, 2, 2, 1, 0, 4'd4, NONE,              2'b10, M0);   // 8
        add(4, 2, 2, 1, 0, 4'd5, NONE,              2'b10, M0);   // 9
        add(4, 2, 2, 1, 0, 4'd6, NONE,              2'b10, M0);   // 10
        add(4, 2, 0, 1, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0);  // 11 FETCH (BRA, stat=0)
        add(4, 2, 0, 1, 0, 4'd3, RD_SEL,            2'b10, M0);   // 12 not taken
        add(4, 2, 0, 1, 0, 4'd4, NONE,              2'b10, M0);   // 13
        add(4, 2, 0, 1, 0, 4'd5, NONE,              2'b10, M0);   // 14
        add(4, 2, 0, 1, 0, 4'd6, NONE,              2'b10, M0);   // 15
        add(7, 0, 5, 1, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0);  // 16 FETCH (BNR mm=0)
        add(7, 0, 5, 1, 0, 4'd3, RD_SEL | PC_WRITE | PC_SEL, 2'b10, M0); // 17 taken rel
        add(7, 0, 5, 1, 0, 4'd4, NONE,              2'b10, M0);   // 18
        add(7, 0, 5, 1, 0, 4'd5, NONE,              2'b10, M0);   // 19
        add(7, 0, 5, 1, 0, 4'd6, NONE,              2'b10, M0);   // 20
        add(1, 0, 0, 1, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0);  // 21 FETCH (LOD)
        add(1, 0, 0, 1, 0, 4'd3, NONE,              2'b10, M0);   // 22 rd_sel=0
        add(1, 0, 0, 1, 0, 4'd4, MM_SEL,            2'b10, M0);   // 23 EXECUTE
        add(1, 0, 0, 0, 0, 4'd5, DM_RE,             2'b10, M0);   // 24 MEM, not ready
        add(1, 0, 0, 0, 0, 4'd7, DM_RE,             2'b10, M0);   // 25 MEMWAIT
        add(1, 0, 0, 0, 0, 4'd7, DM_RE,             2'b10, M0);   // 26 MEMWAIT
        add(1, 0, 0, 1, 0, 4'd7, DM_RE,             2'b10, M0);   // 27 MEMWAIT, ready
        add(1, 0, 0, 1, 0, 4'd6, RF_WE | WB_SEL,    2'b10, M0);   // 28 WRITEBACK
        add(11, 0, 0, 1, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0); // 29 FETCH (op 11)
        add(11, 0, 0, 1, 0, 4'd3, RD_SEL,           2'b10, ILL);  // 30 illegal pulse
        add(11, 0, 0, 1, 0, 4'd4, NONE,             2'b10, M0);   // 31
        add(11, 0, 0, 1, 0, 4'd5, NONE,             2'b10, M0);   // 32
        add(11, 0, 0, 1, 0, 4'd6, NONE,             2'b10, M0);   // 33
        add(2, 8, 0, 0, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0);  // 34 FETCH (STR imm)
        add(2, 8, 0, 0, 0, 4'd3, NONE,              2'b10, M0);   // 35
        add(2, 8, 0, 0, 0, 4'd4, NONE,              2'b11, M0);   // 36 EXECUTE imm
        add(2, 8, 0, 0, 0, 4'd5, DM_WE,             2'b10, M0);   // 37 MEM
        add(2, 8, 0, 0, 0, 4'd7, DM_WE,             2'b10, M0);   // 38 cnt 0
        add(2, 8, 0, 0, 0, 4'd7, DM_WE,             2'b10, M0);   // 39 cnt 1
        add(2, 8, 0, 0, 0, 4'd7, DM_WE,             2'b10, M0);   // 40 cnt 2
        add(2, 8, 0, 0, 0, 4'd7, DM_WE,             2'b10, M0);   // 41 cnt 3 -> timeout
        add(2, 8, 0, 0, 1, 4'd8, NONE,              2'b10, HALTED | BERR); // 42 resume ignored
        add(2, 8, 0, 0, 1, 4'd8, NONE,              2'b10, HALTED | BERR); // 43
        // Segment 2 (rows 44..51): HLT, resume, then into EXECUTE for a reset
        add(15, 0, 0, 1, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0); // 44 FETCH
        add(15, 0, 0, 1, 0, 4'd3, RD_SEL,           2'b10, M0);   // 45 DECODE HLT
        add(15, 0, 0, 1, 0, 4'd8, NONE,             2'b10, HALTED); // 46
        add(15, 0, 0, 1, 0, 4'd8, NONE,             2'b10, HALTED); // 47
        add(15, 0, 0, 1, 1, 4'd8, NONE,             2'b10, HALTED); // 48 resume
        add(8, 0, 0, 1, 0, 4'd2, IR_LOAD | PC_WRITE, 2'b10, M0);  // 49 FETCH
        add(8, 0, 0, 1, 0, 4'd3, RD_SEL,            2'b10, M0);   // 50
        add(8, 0, 0, 1, 0, 4'd4, NONE,              2'b00, M0);   // 51 EXECUTE reg

        rst_f = 1'b0;
        drive(8, 8, 0, 1, 0);
        repeat (2) @(posedge clk);
        #2;
        #1;
        check("reset", 0, {PC_RST, 2'b10, M0, 4'd1});
        rst_f = 1'b1;
        run_rows(0, 43);

        // Asynchronous reset while halted on a bus error clears bus_err without a clock
        rst_f = 1'b0;
        #1;
        check("reset_berr", 0, {PC_RST, 2'b10, M0, 4'd1});
        @(negedge clk);
        rst_f = 1'b1;
        @(posedge clk);
        #2;
        run_rows(44, 51);

        // Asynchronous reset mid-EXECUTE, then release to FETCH on the next edge
        rst_f = 1'b0;
        #1;
        check("reset_exec", 0, {PC_RST, 2'b10, M0, 4'd1});
        @(negedge clk);
        rst_f = 1'b1;
        @(posedge clk);
        #3;
        check("release_fetch", 0, {IR_LOAD | PC_WRITE, 2'b10, M0, 4'd2});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
